// File: rtl/bullet_pool_ctrl.sv
// Player bullet pool: allocates slots on fire requests, moves live bullets up
// on each move tick, and retires them at the screen top or on a collision clear.
module bullet_pool_ctrl #(
  parameter int NUM_SLOTS      = 4,
  parameter int Y_START        = 400,
  parameter int Y_MIN          = 0,
  parameter int STEP           = 1,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    move_tick,
  input  logic                    pause,
  input  logic                    fire_req,
  input  logic [9:0]              fire_x,
  input  logic [NUM_SLOTS-1:0]    hit_clr,
  output logic                    fire_ack,
  output logic [NUM_SLOTS-1:0]    slot_active,
  output logic [10*NUM_SLOTS-1:0] bullet_y,
  output logic [10*NUM_SLOTS-1:0] bullet_x,
  output logic [3:0]              active_count,
  output logic                    ready
);

  localparam int CW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  localparam logic [0:0]           ST_READY    = 1'b0;
  localparam logic [0:0]           ST_COOLDOWN = 1'b1;
  localparam logic [10:0]          Y_LIMIT     = 11'(Y_MIN + STEP);
  localparam logic [9:0]           Y_INIT      = 10'(Y_START);
  localparam logic [9:0]           Y_STEP      = 10'(STEP);
  localparam logic [CW-1:0]        CD_LOAD     = CW'(COOLDOWN_TICKS);
  localparam logic [CW-1:0]        CD_ONE      = CW'(1);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE    = NUM_SLOTS'(1);

  logic [0:0]           state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           y_n [NUM_SLOTS];
  logic [9:0]           x_n [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_n;
  logic [NUM_SLOTS-1:0] free_slots;
  logic [NUM_SLOTS-1:0] alloc_sel;
  logic [3:0]           count_n;
  logic                 move;
  logic                 accept;

  // Free slots come from registered state only, so a slot cleared this cycle
  // becomes allocatable on the next one.
  assign free_slots = ~slot_active;
  assign alloc_sel  = free_slots & (~free_slots + SLOT_ONE);
  assign ready      = (state == ST_READY) && !pause && (|free_slots);
  assign accept     = ready && fire_req;
  assign move       = move_tick && !pause;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    act_n   = slot_active;
    count_n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      y_n[i] = y_q[i];
      x_n[i] = x_q[i];
      if (accept && alloc_sel[i]) begin
        act_n[i] = 1'b1;
        y_n[i]   = Y_INIT;
        x_n[i]   = fire_x;
      end else if (hit_clr[i] && slot_active[i]) begin
        act_n[i] = 1'b0;
        y_n[i]   = Y_INIT;
      end else if (move && slot_active[i]) begin
        if ({1'b0, y_q[i]} < Y_LIMIT) begin
          act_n[i] = 1'b0;
          y_n[i]   = Y_INIT;
        end else begin
          y_n[i] = y_q[i] - Y_STEP;
        end
      end
      count_n = count_n + 4'(act_n[i]);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (accept) begin
      if (COOLDOWN_TICKS > 0) begin
        state_n = ST_COOLDOWN;
        cnt_n   = CD_LOAD;
      end
    end else if (state == ST_COOLDOWN && move) begin
      if (cnt <= CD_ONE) begin
        state_n = ST_READY;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt - CD_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_READY;
      cnt          <= '0;
      fire_ack     <= 1'b0;
      slot_active  <= '0;
      active_count <= '0;
      // NOTE: the slot arrays are small register banks, not RAM, so they are
      // reset explicitly to guarantee no stale bullet survives a reset.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        y_q[i] <= Y_INIT;
        x_q[i] <= '0;
      end
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      fire_ack     <= accept;
      slot_active  <= act_n;
      active_count <= count_n;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        y_q[i] <= y_n[i];
        x_q[i] <= x_n[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bullet_y[10*g +: 10] = y_q[g];
    assign bullet_x[10*g +: 10] = x_q[g];
  end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl: a cycle model feeds a scoreboard queue,
// plus constant checks at the points of interest.
module tb_bullet_pool_ctrl;

  localparam int NS  = 4;
  localparam int YS  = 400;
  localparam int YM  = 0;
  localparam int ST  = 1;
  localparam int CDT = 8;

  logic          clk;
  logic          reset;
  logic          move_tick;
  logic          pause;
  logic          fire_req;
  logic [9:0]    fire_x;
  logic [NS-1:0] hit_clr;
  logic          fire_ack;
  logic [NS-1:0] slot_active;
  logic [39:0]   bullet_y;
  logic [39:0]   bullet_x;
  logic [3:0]    active_count;
  logic          ready;

  bullet_pool_ctrl #(
    .NUM_SLOTS(NS), .Y_START(YS), .Y_MIN(YM), .STEP(ST), .COOLDOWN_TICKS(CDT)
  ) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .pause(pause),
    .fire_req(fire_req), .fire_x(fire_x), .hit_clr(hit_clr),
    .fire_ack(fire_ack), .slot_active(slot_active), .bullet_y(bullet_y),
    .bullet_x(bullet_x), .active_count(active_count), .ready(ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [NS-1:0] m_active;
  logic [9:0]    m_y [NS];
  logic [9:0]    m_x [NS];
  logic          m_cool;
  int            m_cnt;
  logic          m_ack;
  logic [3:0]    m_count;
  logic [127:0]  sb_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dut_vec();
    return {39'd0, fire_ack, slot_active, active_count, bullet_y, bullet_x};
  endfunction

  function automatic logic [127:0] model_vec();
    return {39'd0, m_ack, m_active, m_count,
            m_y[3], m_y[2], m_y[1], m_y[0], m_x[3], m_x[2], m_x[1], m_x[0]};
  endfunction

  function automatic logic model_ready();
    return !m_cool && !pause && (m_active != 4'hF);
  endfunction

  task automatic model_reset();
    m_active = '0;
    for (int i = 0; i < NS; i++) begin
      m_y[i] = 10'(YS);
      m_x[i] = '0;
    end
    m_cool  = 1'b0;
    m_cnt   = 0;
    m_ack   = 1'b0;
    m_count = '0;
    sb_q.delete();
  endtask

  task automatic model_step();
    logic acc;
    int   idx;
    acc = model_ready() && fire_req;
    idx = -1;
    for (int i = 0; i < NS; i++)
      if (!m_active[i] && idx < 0) idx = i;
    for (int i = 0; i < NS; i++) begin
      if (acc && i == idx) begin
        m_active[i] = 1'b1;
        m_y[i]      = 10'(YS);
        m_x[i]      = fire_x;
      end else if (hit_clr[i] && m_active[i]) begin
        m_active[i] = 1'b0;
        m_y[i]      = 10'(YS);
      end else if (move_tick && !pause && m_active[i]) begin
        if (int'(m_y[i]) < YM + ST) begin
          m_active[i] = 1'b0;
          m_y[i]      = 10'(YS);
        end else begin
          m_y[i] = m_y[i] - 10'(ST);
        end
      end
    end
    if (acc) begin
      m_cool = 1'b1;
      m_cnt  = CDT;
    end else if (m_cool && move_tick && !pause) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_cool = 1'b0;
    end
    m_ack   = acc;
    m_count = 4'($countones(m_active));
  endtask

  // One clock: model predicts, result queued, compared #1 after the edge.
  task automatic cycle();
    logic [127:0] e;
    model_step();
    sb_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_outputs", dut_vec(), e);
    check("sb_ready", 128'(ready), 128'(model_ready()));
  endtask

  initial begin
    logic [9:0] prev_y1;
    clk = 0; reset = 1; move_tick = 0; pause = 0;
    fire_req = 0; fire_x = '0; hit_clr = '0;
    model_reset();
    #12;
    check("reset_vec", dut_vec(), model_vec());
    check("reset_active", 128'(slot_active), 128'(0));
    check("reset_ready", 128'(ready), 128'(1));
    @(negedge clk) reset = 0;

    // First shot lands in slot 0
    fire_req = 1; fire_x = 10'd120;
    cycle();
    check("fire1_ack", 128'(fire_ack), 128'(1));
    check("fire1_active", 128'(slot_active), 128'(4'b0001));
    check("fire1_y0", 128'(bullet_y[9:0]), 128'(400));
    check("fire1_x0", 128'(bullet_x[9:0]), 128'(120));
    check("fire1_count", 128'(active_count), 128'(1));

    // Held request: no ack during cooldown, second ack after 8 ticks
    fire_x = 10'd200;
    repeat (3) begin
      cycle();
      check("cd_idle_noack", 128'(fire_ack), 128'(0));
    end
    move_tick = 1;
    repeat (8) begin
      cycle();
      check("cd_tick_noack", 128'(fire_ack), 128'(0));
    end
    move_tick = 0;
    cycle();
    check("fire2_ack", 128'(fire_ack), 128'(1));
    check("fire2_active", 128'(slot_active), 128'(4'b0011));
    check("fire2_x1", 128'(bullet_x[19:10]), 128'(200));
    check("fire2_y0", 128'(bullet_y[9:0]), 128'(392));
    fire_req = 0;

    // Slot 0 climbs to the top and retires
    move_tick = 1;
    repeat (391) cycle();
    check("top_y0_1", 128'(bullet_y[9:0]), 128'(1));
    cycle();
    check("top_y0_0", 128'(bullet_y[9:0]), 128'(0));
    cycle();
    check("top_retire_active", 128'(slot_active), 128'(4'b0010));
    check("top_retire_y0", 128'(bullet_y[9:0]), 128'(400));
    check("top_retire_x0", 128'(bullet_x[9:0]), 128'(120));
    check("top_retire_count", 128'(active_count), 128'(1));
    move_tick = 0;

    reset = 1;
    model_reset();
    #1;
    check("reset2_vec", dut_vec(), model_vec());
    @(negedge clk) reset = 0;

    // Fill the pool
    for (int s = 0; s < NS; s++) begin
      fire_req = 1; fire_x = 10'(10 * (s + 1));
      cycle();
      fire_req = 0;
      move_tick = 1;
      repeat (CDT) cycle();
      move_tick = 0;
    end
    fire_req = 1;
    cycle();
    check("full_noack", 128'(fire_ack), 128'(0));
    check("full_ready", 128'(ready), 128'(0));
    hit_clr = 4'b0100;
    cycle();
    hit_clr = '0;
    check("freed_same_cycle_noack", 128'(fire_ack), 128'(0));
    check("freed_active", 128'(slot_active), 128'(4'b1011));
    fire_x = 10'd333;
    cycle();
    fire_req = 0;
    check("refill_ack", 128'(fire_ack), 128'(1));
    check("refill_active", 128'(slot_active), 128'(4'b1111));
    check("refill_x2", 128'(bullet_x[29:20]), 128'(333));

    // Fire in the same cycle as a move tick
    move_tick = 1;
    repeat (CDT) cycle();
    move_tick = 0;
    hit_clr = 4'b0001;
    cycle();
    hit_clr = '0;
    prev_y1 = m_y[1];
    fire_req = 1; fire_x = 10'd77; move_tick = 1;
    cycle();
    fire_req = 0; move_tick = 0;
    check("tickfire_y0", 128'(bullet_y[9:0]), 128'(400));
    check("tickfire_x0", 128'(bullet_x[9:0]), 128'(77));
    check("tickfire_y1", 128'(bullet_y[19:10]), 128'(prev_y1 - 10'd1));

    // Pause: hit_clr still acts, nothing moves, nothing is accepted
    move_tick = 1;
    repeat (CDT) cycle();
    move_tick = 0;
    pause = 1;
    hit_clr = 4'b0010;
    cycle();
    hit_clr = '0;
    check("pause_hit", 128'(slot_active), 128'(4'b1101));
    prev_y1 = m_y[0];
    fire_req = 1; move_tick = 1;
    repeat (10) begin
      cycle();
      check("pause_noack", 128'(fire_ack), 128'(0));
    end
    check("pause_y0_frozen", 128'(bullet_y[9:0]), 128'(prev_y1));
    check("pause_ready", 128'(ready), 128'(0));
    pause = 0; fire_req = 0; move_tick = 0;
    cycle();

    // Asynchronous reset with three bullets live
    @(posedge clk);
    #3;
    reset = 1;
    model_reset();
    #1;
    check("midreset_active", 128'(slot_active), 128'(0));
    check("midreset_y", 128'(bullet_y), 128'({4{10'd400}}));
    check("midreset_x", 128'(bullet_x), 128'(0));
    check("midreset_count", 128'(active_count), 128'(0));
    check("midreset_ack", 128'(fire_ack), 128'(0));
    @(negedge clk) reset = 0;
    fire_req = 1; fire_x = 10'd55;
    cycle();
    fire_req = 0;
    check("postreset_active", 128'(slot_active), 128'(4'b0001));
    check("postreset_x0", 128'(bullet_x[9:0]), 128'(55));
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
